fetch_decode_receiver: RTL and testbench
========================================

// Module: fetch_decode_receiver
// PURPOSE
//  Decode-side receiving end of the fetch-to-decode bus. Accepts fetched
//  instruction packets from the fetch stage under a valid/ready handshake and
//  buffers them in a small FIFO. Splits each packet into decoded fields for the
//  decode/execute pipeline. Store-stage redirects flush all buffered,
//  wrong-path instructions.
// PARAMETERS
//  DEPTH      4   FIFO entries; power of two, >=2
//  PC_W       64  program counter width (uint64_t)
//  INSN_W     32  raw instruction word width
// PORTS
//  clk            in   1       core clock, all state on posedge
//  rst_n          in   1       asynchronous active-low reset
//  fetch_valid    in   1       fetch presents a packet
//  fetch_pc       in   PC_W    PC of presented instruction
//  fetch_insn     in   INSN_W  raw instruction word
//  fetch_ready    out  1       receiver can accept a packet this cycle
//  flush          in   1       store-stage redirect; discard all buffered packets
//  dec_valid      out  1       decoded packet available
//  dec_ready      in   1       downstream consumes packet
//  dec_pc         out  PC_W    PC of head packet
//  dec_opcode     out  8       insn[7:0]
//  dec_rd         out  5       insn[12:8]
//  dec_rs1        out  5       insn[17:13]
//  dec_rs2        out  5       insn[22:18]
//  dec_imm        out  64      insn[31:23] sign-extended to 64 bits
//  dec_illegal    out  1       opcode >= OPC_COUNT
//  stall_cycles   out  32      saturating count of cycles with fetch_valid && !fetch_ready
// BEHAVIOUR
//  - Reset (rst_n=0, async): FIFO empty; count=0; fetch_ready=1; dec_valid=0.
//    stall_cycles=0. Decoded outputs=0. Rst_n deasserted mid-transfer drops the packet.
//  - Push: fetch_valid && fetch_ready at posedge writes {pc,insn} at wr_ptr.
//  - fetch_ready = (count < DEPTH), derived from registered count only.
//    No pass-through when full: a same-cycle pop does not enable a push.
//  - Pop: dec_valid && dec_ready at posedge advances rd_ptr.
//    dec_valid = (count != 0).
//  - Latency: packet pushed at edge N is visible on dec_* after edge N (cycle N+1).
//  - Output fields are combinational decode of FIFO head entry. They hold when
//    dec_valid=1 && dec_ready=0 and are don't-care when dec_valid=0.
//  - Ptrs are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.
//    Simultaneous push+pop when 0<count<DEPTH leaves count unchanged.
//  - Flush: at posedge with flush=1, ptrs and count are cleared. Any same-cycle
//    push or pop is ignored; flush wins. Cycle after flush: dec_valid=0, fetch_ready=1.
//  - stall_cycles increments when fetch_valid && !fetch_ready && !flush.
//    It saturates at 32'hFFFF_FFFF and is not cleared by flush.
//  - FSM tracks fill state: EMPTY (count=0), PARTIAL, FULL (count=DEPTH).
//    Transitions follow the push/pop/flush rules above. It is used for
//    assertions and debug only and drives no output.
// STRUCTURE
//  - Shared package decode_pkg: OPC_COUNT constant (localparam 8'd32).
//    Field offset constants. Struct FetchPacket {pc, insn}.
//    Struct DecodedInsn {opcode, rd, rs1, rs2, imm, illegal}.
//    Function decode_insn(insn) -> DecodedInsn.
//  - One sub-module: fetch_decode_fifo (DEPTH x FetchPacket, push/pop/flush,
//    full/empty/count). Top level holds the handshake logic, decode and
//    stall counter.
// TESTING
//  1. Reset, then push pc=0x1000, insn=0x0080_1A05 with dec_ready=1
//     -> next cycle: dec_valid=1, opcode=0x05, rd=0x1A, imm=1; one cycle later dec_valid=0.
//  2. dec_ready=0, push 4 packets -> fetch_ready=0 after 4th. Hold fetch_valid
//     3 cycles -> stall_cycles=3. Set dec_ready=1 -> packets drain in push order.
//  3. Full FIFO, fetch_valid=1, dec_ready=1 in same cycle -> only the pop occurs.
//     fetch_ready=1 on the next cycle, push accepted the cycle after.
//  4. 2 entries buffered, assert flush with fetch_valid=1 and dec_ready=1
//     -> next cycle dec_valid=0, count=0, fetch_ready=1; no packet retained.
//  5. insn[31:23]=9'h1FF -> dec_imm=64'hFFFF_FFFF_FFFF_FFFF. opcode=0x20 -> dec_illegal=1.
//  6. Drop rst_n asynchronously mid-stream with 3 entries buffered -> outputs
//     reset immediately, without waiting for clk edge. After release, 9 pushes
//     with pops exercise pointer wrap with no loss or reordering.

Source files
------------

// File: rtl/decode_pkg.sv
// decode_pkg: shared packet/decoded-field types, field offsets and the instruction decode helper.
package decode_pkg;
  localparam int XLEN = 64;
  localparam int ILEN = 32;
  localparam logic [7:0] OPC_COUNT = 8'd32;
  localparam int OPC_LSB = 0;
  localparam int RD_LSB = 8;
  localparam int RS1_LSB = 13;
  localparam int RS2_LSB = 18;
  localparam int IMM_LSB = 23;
  localparam int IMM_W = ILEN - IMM_LSB;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] insn;
  } fetch_packet_t;
  typedef struct packed {
    logic [7:0] opcode;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [63:0] imm;
    logic illegal;
  } decoded_insn_t;
  function automatic decoded_insn_t decode_insn(input logic [ILEN-1:0] insn);
    decoded_insn_t d;
    d.opcode = insn[OPC_LSB +: 8];
    d.rd = insn[RD_LSB +: 5];
    d.rs1 = insn[RS1_LSB +: 5];
    d.rs2 = insn[RS2_LSB +: 5];
    d.imm = {{(64-IMM_W){insn[ILEN-1]}}, insn[IMM_LSB +: IMM_W]};
    d.illegal = insn[OPC_LSB +: 8] >= OPC_COUNT;
    return d;
  endfunction
endpackage

// File: rtl/fetch_decode_fifo.sv
// fetch_decode_fifo: DEPTH-entry packet FIFO with push/pop and a flush that overrides both.
module fetch_decode_fifo
  import decode_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_packet_t            wr_data,
  output fetch_packet_t            rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  fetch_packet_t mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;
  always_comb begin
    wr_ptr_d = flush ? '0 : wr_ptr_q + AW'(push);
    rd_ptr_d = flush ? '0 : rd_ptr_q + AW'(pop);
    count_d = flush ? '0 : count_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  always_ff @(posedge clk)
    if (push && !flush) mem_q[wr_ptr_q] <= wr_data;
  assign rd_data = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full = count_q == (AW+1)'(DEPTH);
  assign empty = count_q == '0;
endmodule

// File: rtl/fetch_decode_receiver.sv
// fetch_decode_receiver: accepts fetch packets into a FIFO, presents the head as decoded fields,
// flushes on store-stage redirect and counts back-pressure cycles.
module fetch_decode_receiver
  import decode_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W = 64,
  parameter int INSN_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_valid,
  input  logic [PC_W-1:0]   fetch_pc,
  input  logic [INSN_W-1:0] fetch_insn,
  output logic              fetch_ready,
  input  logic              flush,
  output logic              dec_valid,
  input  logic              dec_ready,
  output logic [PC_W-1:0]   dec_pc,
  output logic [7:0]        dec_opcode,
  output logic [4:0]        dec_rd,
  output logic [4:0]        dec_rs1,
  output logic [4:0]        dec_rs2,
  output logic [63:0]       dec_imm,
  output logic              dec_illegal,
  output logic [31:0]       stall_cycles
);
  localparam int CW = $clog2(DEPTH) + 1;
  typedef enum logic [1:0] {FILL_EMPTY, FILL_PARTIAL, FILL_FULL} fill_e;
  fill_e fill_q, fill_d;
  logic push, pop, full, empty;
  logic [CW-1:0] count;
  fetch_packet_t head;
  decoded_insn_t dec;
  logic [31:0] stall_q, stall_d;
  assign fetch_ready = !full;
  assign dec_valid = !empty;
  assign push = fetch_valid && fetch_ready;
  assign pop = dec_valid && dec_ready;
  fetch_decode_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .pop(pop),
    .flush(flush),
    .wr_data('{pc: fetch_pc, insn: fetch_insn}),
    .rd_data(head),
    .count(count),
    .full(full),
    .empty(empty)
  );
  // Fields read as zero while nothing is buffered so reset leaves every output at 0.
  always_comb begin
    dec = decode_insn(head.insn);
    dec_pc = dec_valid ? head.pc : '0;
    dec_opcode = dec_valid ? dec.opcode : '0;
    dec_rd = dec_valid ? dec.rd : '0;
    dec_rs1 = dec_valid ? dec.rs1 : '0;
    dec_rs2 = dec_valid ? dec.rs2 : '0;
    dec_imm = dec_valid ? dec.imm : '0;
    dec_illegal = dec_valid && dec.illegal;
  end
  always_comb begin
    fill_d = fill_q;
    stall_d = (fetch_valid && !fetch_ready && !flush && stall_q != '1) ? stall_q + 32'd1 : stall_q;
    if (flush) fill_d = FILL_EMPTY;
    else if (push != pop)
      fill_d = (push && count == CW'(DEPTH - 1)) ? FILL_FULL :
               (pop && count == CW'(1)) ? FILL_EMPTY : FILL_PARTIAL;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      fill_q <= FILL_EMPTY;
      stall_q <= '0;
    end else begin
      fill_q <= fill_d;
      stall_q <= stall_d;
    end
  assign stall_cycles = stall_q;
  // Fill state is debug-only; it must always agree with the FIFO occupancy.
  fill_tracks_count: assert property (@(posedge clk) disable iff (!rst_n)
    ((fill_q == FILL_EMPTY) == empty) && ((fill_q == FILL_FULL) == full));
endmodule

// File: tb/tb_fetch_decode_receiver.sv
// tb_fetch_decode_receiver: directed scenarios plus random traffic, scoreboarded against a queue model.
module tb_fetch_decode_receiver;
  localparam int DEPTH = 4;
  logic clk = 0, rst_n = 0, fetch_valid = 0, flush = 0, dec_ready = 0;
  logic [63:0] fetch_pc = '0;
  logic [31:0] fetch_insn = '0;
  logic fetch_ready, dec_valid, dec_illegal;
  logic [63:0] dec_pc, dec_imm;
  logic [7:0] dec_opcode;
  logic [4:0] dec_rd, dec_rs1, dec_rs2;
  logic [31:0] stall_cycles;
  int checks = 0, errors = 0;
  typedef struct { logic [63:0] pc; logic [31:0] insn; } pkt_t;
  pkt_t exp_q[$];
  logic [31:0] exp_stall = '0;

  fetch_decode_receiver #(.DEPTH(DEPTH), .PC_W(64), .INSN_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
    .fetch_insn(fetch_insn), .fetch_ready(fetch_ready), .flush(flush),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_pc(dec_pc),
    .dec_opcode(dec_opcode), .dec_rd(dec_rd), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_imm(dec_imm), .dec_illegal(dec_illegal), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_imm(input logic [31:0] insn);
    logic [63:0] v;
    v = 64'(insn >> 23);
    return v >= 64'd256 ? v - 64'd512 : v;
  endfunction

  // Reference: a plain bounded queue; flush empties it, full blocks pushes.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      exp_stall = '0;
    end else if (flush) exp_q.delete();
    else begin
      bit do_push;
      do_push = fetch_valid && exp_q.size() < DEPTH;
      if (fetch_valid && !do_push && exp_stall != 32'hFFFF_FFFF) exp_stall++;
      if (dec_ready && exp_q.size() != 0) void'(exp_q.pop_front());
      if (do_push) exp_q.push_back('{fetch_pc, fetch_insn});
    end
  end

  always @(negedge clk) if (rst_n) begin
    chk("dec_valid", 64'(dec_valid), 64'(exp_q.size() != 0));
    chk("fetch_ready", 64'(fetch_ready), 64'(exp_q.size() < DEPTH));
    chk("stall_cycles", 64'(stall_cycles), 64'(exp_stall));
    if (exp_q.size() != 0) begin
      chk("head_pc", dec_pc, exp_q[0].pc);
      chk("head_opcode", 64'(dec_opcode), 64'(exp_q[0].insn % 256));
      chk("head_rd", 64'(dec_rd), 64'((exp_q[0].insn >> 8) % 32));
      chk("head_rs1", 64'(dec_rs1), 64'((exp_q[0].insn >> 13) % 32));
      chk("head_rs2", 64'(dec_rs2), 64'((exp_q[0].insn >> 18) % 32));
      chk("head_imm", dec_imm, ref_imm(exp_q[0].insn));
      chk("head_illegal", 64'(dec_illegal), 64'((exp_q[0].insn % 256) >= 32));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_n(input int n, input logic [63:0] base);
    for (int i = 0; i < n; i++) begin
      fetch_valid = 1;
      fetch_pc = base + 64'(4 * i);
      fetch_insn = $urandom;
      step();
    end
    fetch_valid = 0;
  endtask

  initial begin
    @(posedge clk);
    #2;
    chk("rst_dec_valid", 64'(dec_valid), 64'd0);
    chk("rst_fetch_ready", 64'(fetch_ready), 64'd1);
    chk("rst_stall", 64'(stall_cycles), 64'd0);
    chk("rst_dec_pc", dec_pc, 64'd0);
    chk("rst_dec_imm", dec_imm, 64'd0);
    #1 rst_n = 1;
    fetch_valid = 1;
    fetch_pc = 64'h1000;
    fetch_insn = 32'h0080_1A05;
    dec_ready = 1;
    step();
    fetch_valid = 0;
    chk("t1_valid", 64'(dec_valid), 64'd1);
    chk("t1_opcode", 64'(dec_opcode), 64'h05);
    chk("t1_rd", 64'(dec_rd), 64'h1A);
    chk("t1_imm", dec_imm, 64'd1);
    chk("t1_pc", dec_pc, 64'h1000);
    step();
    chk("t1_drained", 64'(dec_valid), 64'd0);
    dec_ready = 0;
    push_n(4, 64'h2000);
    chk("t2_full", 64'(fetch_ready), 64'd0);
    fetch_valid = 1;
    repeat (3) step();
    fetch_valid = 0;
    chk("t2_stall", 64'(stall_cycles), 64'd3);
    dec_ready = 1;
    for (int i = 0; i < 4; i++) begin
      chk("t2_order", dec_pc, 64'h2000 + 64'(4 * i));
      step();
    end
    chk("t2_empty", 64'(dec_valid), 64'd0);
    dec_ready = 0;
    push_n(4, 64'h4000);
    fetch_valid = 1;
    fetch_pc = 64'h5000;
    dec_ready = 1;
    step();
    chk("t3_pop_only", 64'(fetch_ready), 64'd1);
    chk("t3_head", dec_pc, 64'h4004);
    dec_ready = 0;
    step();
    fetch_valid = 0;
    chk("t3_push_next", 64'(fetch_ready), 64'd0);
    chk("t3_stall", 64'(stall_cycles), 64'd4);
    dec_ready = 1;
    repeat (4) step();
    dec_ready = 0;
    push_n(2, 64'h6000);
    flush = 1;
    fetch_valid = 1;
    dec_ready = 1;
    step();
    flush = 0;
    fetch_valid = 0;
    chk("t4_valid", 64'(dec_valid), 64'd0);
    chk("t4_ready", 64'(fetch_ready), 64'd1);
    step();
    chk("t4_retained", 64'(dec_valid), 64'd0);
    fetch_valid = 1;
    fetch_insn = 32'hFF80_0020;
    dec_ready = 0;
    step();
    fetch_valid = 0;
    chk("t5_imm", dec_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("t5_illegal", 64'(dec_illegal), 64'd1);
    dec_ready = 1;
    step();
    dec_ready = 0;
    push_n(3, 64'h7000);
    @(posedge clk);
    #3 rst_n = 0;
    #1;
    chk("t6_async_valid", 64'(dec_valid), 64'd0);
    chk("t6_async_ready", 64'(fetch_ready), 64'd1);
    chk("t6_async_stall", 64'(stall_cycles), 64'd0);
    chk("t6_async_pc", dec_pc, 64'd0);
    #3 rst_n = 1;
    dec_ready = 1;
    push_n(9, 64'h8000);
    repeat (2) step();
    for (int i = 0; i < 500; i++) begin
      fetch_valid = $urandom_range(0, 3) != 0;
      dec_ready = $urandom_range(0, 2) != 0;
      flush = $urandom_range(0, 24) == 0;
      fetch_pc = {$urandom, $urandom};
      fetch_insn = $urandom;
      step();
    end
    fetch_valid = 0;
    flush = 0;
    dec_ready = 1;
    repeat (6) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
